// File: rtl/lbm_pkg.sv
// ---------------------------------------------------------------------------
// lbm_pkg
// Shared definitions for the D2Q9 lattice Boltzmann streaming sweeper.
//   dir_t            : direction index 0..8
//   CX / CY          : lattice velocity components per direction
//   OPP              : opposite direction per direction (used by bounce-back)
//   boundary_mode_e  : PERIODIC, CHANNEL (walls at y edges), CLOSED (all walls)
//   sweep_state_e    : sweeper FSM states
//   wrap()           : single-step modular wrap of a coordinate into [0, n)
// ---------------------------------------------------------------------------
package lbm_pkg;

    localparam int NUM_DIRS = 9;

    typedef logic [3:0] dir_t;

    // Direction order: rest, E, N, W, S, NE, NW, SW, SE
    localparam int CX [NUM_DIRS] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    localparam int CY [NUM_DIRS] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

    localparam dir_t OPP [NUM_DIRS] = '{4'd0, 4'd3, 4'd4, 4'd1, 4'd2,
                                        4'd7, 4'd8, 4'd5, 4'd6};

    typedef enum logic [1:0] {
        PERIODIC = 2'd0,
        CHANNEL  = 2'd1,
        CLOSED   = 2'd2
    } boundary_mode_e;

    typedef enum logic [1:0] {
        SWEEP_IDLE = 2'd0,
        SWEEP_RUN  = 2'd1,
        SWEEP_DONE = 2'd2
    } sweep_state_e;

    // A pull source is at most one cell outside the domain, so a single
    // add/subtract of n is enough to bring it back in range.
    function automatic int wrap(input int v, input int n);
        if (v < 0) begin
            return v + n;
        end else if (v >= n) begin
            return v - n;
        end
        return v;
    endfunction

endpackage

// File: rtl/lbm_stream_sweeper_if.sv
// ---------------------------------------------------------------------------
// lbm_stream_sweeper_if
// Cell stream from the sweeper to the collision/streaming consumer.
//   addr_valid : cell_addr/src_addr/bounce/step_last are meaningful
//   addr_ready : consumer accepts the presented cell
//   cell_addr  : destination cell, y*NX+x
//   src_addr   : pull source for direction k in bits [k*AW +: AW]
//   bounce     : bit k set when source k lies outside the domain
//   step_last  : presented cell is the last one of its timestep
//   state      : sweeper FSM state, for observation only
//
// Handshake: a cell transfers on every rising edge where addr_valid and
// addr_ready are both high. Once addr_valid rises it stays high, and every
// payload field stays stable, until that transfer happens. addr_valid never
// depends combinationally on addr_ready.
// ---------------------------------------------------------------------------
interface lbm_stream_sweeper_if #(
    parameter int ADDRESS_WIDTH = 8
) ();
    import lbm_pkg::*;

    logic                              addr_valid;
    logic                              addr_ready;
    logic [ADDRESS_WIDTH-1:0]          cell_addr;
    logic [NUM_DIRS*ADDRESS_WIDTH-1:0] src_addr;
    logic [NUM_DIRS-1:0]               bounce;
    logic                              step_last;
    sweep_state_e                      state;

    modport master (
        output addr_valid, cell_addr, src_addr, bounce, step_last, state,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, cell_addr, src_addr, bounce, step_last, state,
        output addr_ready
    );

endinterface

// File: rtl/lbm_neighbor_addr.sv
// ---------------------------------------------------------------------------
// lbm_neighbor_addr
// Combinational pull-scheme neighbour map for one D2Q9 cell.
//   x, y     : in  cell coordinates
//   src_addr : out source cell address per direction, [k*AW +: AW]
//   bounce   : out bit k set when the source is outside the domain; the
//              source address is then the cell itself, so the consumer
//              reads the opposite population from its own cell
// Periodic axes wrap; wall axes flag bounce-back. Which axes are walls is
// fixed by BOUNDARY_MODE.
// ---------------------------------------------------------------------------
module lbm_neighbor_addr
    import lbm_pkg::*;
#(
    parameter int NX            = 16,
    parameter int NY            = 16,
    parameter int BOUNDARY_MODE = 0,
    parameter int ADDRESS_WIDTH = $clog2(NX*NY),
    parameter int X_WIDTH       = (NX > 1) ? $clog2(NX) : 1,
    parameter int Y_WIDTH       = (NY > 1) ? $clog2(NY) : 1
) (
    input  logic [X_WIDTH-1:0]                x,
    input  logic [Y_WIDTH-1:0]                y,
    output logic [NUM_DIRS*ADDRESS_WIDTH-1:0] src_addr,
    output logic [NUM_DIRS-1:0]               bounce
);

    localparam bit X_WALL = (BOUNDARY_MODE == int'(CLOSED));
    localparam bit Y_WALL = (BOUNDARY_MODE != int'(PERIODIC));

    always_comb begin
        int   xi;
        int   yi;
        int   cell_i;
        int   sx;
        int   sy;
        logic outside;

        src_addr = '0;
        bounce   = '0;
        xi       = int'(x);
        yi       = int'(y);
        cell_i   = yi * NX + xi;
        sx       = 0;
        sy       = 0;
        outside  = 1'b0;

        for (int k = 0; k < NUM_DIRS; k++) begin
            // Pull: the population arriving along k came from (x-cx, y-cy).
            sx      = xi - CX[k];
            sy      = yi - CY[k];
            outside = 1'b0;

            if (sx < 0 || sx >= NX) begin
                if (X_WALL) begin
                    outside = 1'b1;
                end else begin
                    sx = wrap(sx, NX);
                end
            end

            if (sy < 0 || sy >= NY) begin
                if (Y_WALL) begin
                    outside = 1'b1;
                end else begin
                    sy = wrap(sy, NY);
                end
            end

            bounce[k] = outside;
            src_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
                ADDRESS_WIDTH'(outside ? cell_i : (sy * NX + sx));
        end
    end

endmodule

// File: rtl/lbm_stream_sweeper.sv
// ---------------------------------------------------------------------------
// lbm_stream_sweeper
// Walks every cell of an NX x NY D2Q9 lattice once per timestep for a
// requested number of timesteps, presenting each cell with its nine pull
// sources and bounce-back flags on a valid/ready stream.
//   CLOCK_50   : in  clock, rising edge
//   RESET      : in  synchronous active-low reset
//   start      : in  run request, honoured only while idle
//   n_steps    : in  timesteps for the run, sampled with start, clamped to
//                    MAX_TIME
//   bus        : master side of the cell stream (see lbm_stream_sweeper_if)
//   step_count : out completed timesteps in the current run
//   busy       : out run in progress
//   done       : out one-cycle pulse after the final cell transfer
// The next cell's neighbours are computed from the next-state coordinates
// so every stream field leaves a register.
// ---------------------------------------------------------------------------
module lbm_stream_sweeper
    import lbm_pkg::*;
#(
    parameter int NX               = 16,
    parameter int NY               = 16,
    parameter int MAX_TIME         = 100,
    parameter int ADDRESS_WIDTH    = $clog2(NX*NY),
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME+1),
    parameter int BOUNDARY_MODE    = 0
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic                        start,
    input  logic [TIME_COUNT_WIDTH-1:0] n_steps,
    lbm_stream_sweeper_if.master        bus,
    output logic [TIME_COUNT_WIDTH-1:0] step_count,
    output logic                        busy,
    output logic                        done
);

    localparam int X_WIDTH = (NX > 1) ? $clog2(NX) : 1;
    localparam int Y_WIDTH = (NY > 1) ? $clog2(NY) : 1;

    localparam logic [X_WIDTH-1:0]          X_LAST     = X_WIDTH'(NX - 1);
    localparam logic [Y_WIDTH-1:0]          Y_LAST     = Y_WIDTH'(NY - 1);
    localparam logic [TIME_COUNT_WIDTH-1:0] STEP_CLAMP = TIME_COUNT_WIDTH'(MAX_TIME);

    sweep_state_e                      state, state_nxt;
    logic [X_WIDTH-1:0]                x_q, x_nxt;
    logic [Y_WIDTH-1:0]                y_q, y_nxt;
    logic [TIME_COUNT_WIDTH-1:0]       step_q, step_nxt;
    logic [TIME_COUNT_WIDTH-1:0]       target_q, target_nxt;
    logic                              load;

    logic [ADDRESS_WIDTH-1:0]          cell_q;
    logic [ADDRESS_WIDTH-1:0]          cell_nxt;
    logic [NUM_DIRS*ADDRESS_WIDTH-1:0] src_q;
    logic [NUM_DIRS*ADDRESS_WIDTH-1:0] nb_src;
    logic [NUM_DIRS-1:0]               bounce_q;
    logic [NUM_DIRS-1:0]               nb_bounce;
    logic                              last_q;
    logic                              last_cell;

    lbm_neighbor_addr #(
        .NX            (NX),
        .NY            (NY),
        .BOUNDARY_MODE (BOUNDARY_MODE),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .X_WIDTH       (X_WIDTH),
        .Y_WIDTH       (Y_WIDTH)
    ) u_neighbor (
        .x        (x_nxt),
        .y        (y_nxt),
        .src_addr (nb_src),
        .bounce   (nb_bounce)
    );

    assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);
    assign cell_nxt  = ADDRESS_WIDTH'(int'(y_nxt) * NX + int'(x_nxt));

    // Next-state logic. load marks a new cell being presented next cycle.
    always_comb begin
        state_nxt  = state;
        x_nxt      = x_q;
        y_nxt      = y_q;
        step_nxt   = step_q;
        target_nxt = target_q;
        load       = 1'b0;

        case (state)
            SWEEP_IDLE: begin
                if (start) begin
                    x_nxt    = '0;
                    y_nxt    = '0;
                    step_nxt = '0;
                    if (n_steps == '0) begin
                        state_nxt = SWEEP_DONE;
                    end else begin
                        target_nxt = (n_steps > STEP_CLAMP) ? STEP_CLAMP : n_steps;
                        state_nxt  = SWEEP_RUN;
                        load       = 1'b1;
                    end
                end
            end

            SWEEP_RUN: begin
                // addr_valid is high throughout SWEEP_RUN, so ready alone
                // completes the handshake.
                if (bus.addr_ready) begin
                    if (last_cell) begin
                        step_nxt = step_q + TIME_COUNT_WIDTH'(1);
                        if (step_nxt == target_q) begin
                            state_nxt = SWEEP_DONE;
                        end else begin
                            // Next timestep starts immediately, no bubble.
                            x_nxt = '0;
                            y_nxt = '0;
                            load  = 1'b1;
                        end
                    end else begin
                        load = 1'b1;
                        if (x_q == X_LAST) begin
                            x_nxt = '0;
                            y_nxt = y_q + Y_WIDTH'(1);
                        end else begin
                            x_nxt = x_q + X_WIDTH'(1);
                        end
                    end
                end
            end

            SWEEP_DONE: begin
                state_nxt = SWEEP_IDLE;
            end

            default: begin
                state_nxt = SWEEP_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            state    <= SWEEP_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            step_q   <= '0;
            target_q <= '0;
            cell_q   <= '0;
            src_q    <= '0;
            bounce_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            step_q   <= step_nxt;
            target_q <= target_nxt;
            if (load) begin
                cell_q   <= cell_nxt;
                src_q    <= nb_src;
                bounce_q <= nb_bounce;
                last_q   <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
            end
        end
    end

    assign bus.addr_valid = (state == SWEEP_RUN);
    assign bus.cell_addr  = cell_q;
    assign bus.src_addr   = src_q;
    assign bus.bounce     = bounce_q;
    assign bus.step_last  = last_q;
    assign bus.state      = state;

    assign step_count = step_q;
    assign busy       = (state == SWEEP_RUN);
    assign done       = (state == SWEEP_DONE);

endmodule

// File: tb/tb_lbm_stream_sweeper.sv
// ---------------------------------------------------------------------------
// tb_lbm_stream_sweeper
// Three 4x4 sweepers, one per boundary mode, driven one at a time. Expected
// cells for a run are queued when the run is started and popped on each
// transfer; run length, done timing, stall stability, clamping, reset and
// ignored restarts are checked by directed steps.
// ---------------------------------------------------------------------------
module tb_lbm_stream_sweeper;
    import lbm_pkg::*;

    localparam int NXT = 4;
    localparam int NYT = 4;
    localparam int AW  = 4;
    localparam int TW  = 7;
    localparam int NC  = NXT * NYT;
    localparam int W   = 50;

    localparam int DX [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    localparam int DY [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

    logic          clk;
    logic          rst_n;
    logic [2:0]    start_v;
    logic [TW-1:0] nsteps;
    logic          ready;

    logic [2:0]    vld_a;
    logic [2:0]    last_a;
    logic [2:0]    busy_a;
    logic [2:0]    done_a;
    logic [AW-1:0] cell_a   [3];
    logic [9*AW-1:0] src_a  [3];
    logic [8:0]    bounce_a [3];
    logic [TW-1:0] step_a   [3];
    sweep_state_e  state_a  [3];

    logic [W-1:0]  exp_q [$];
    int            checks;
    int            errors;
    int            sel;
    int            hs_count;
    logic          prev_v;
    logic          prev_r;
    logic [50:0]   prev_bundle;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lbm_stream_sweeper_if #(.ADDRESS_WIDTH(AW)) bus ();
        assign bus.addr_ready = ready;

        lbm_stream_sweeper #(
            .NX            (NXT),
            .NY            (NYT),
            .MAX_TIME      (100),
            .ADDRESS_WIDTH (AW),
            .TIME_COUNT_WIDTH (TW),
            .BOUNDARY_MODE (g)
        ) dut (
            .CLOCK_50   (clk),
            .RESET      (rst_n),
            .start      (start_v[g]),
            .n_steps    (nsteps),
            .bus        (bus.master),
            .step_count (step_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g])
        );

        assign vld_a[g]    = bus.addr_valid;
        assign last_a[g]   = bus.step_last;
        assign cell_a[g]   = bus.cell_addr;
        assign src_a[g]    = bus.src_addr;
        assign bounce_a[g] = bus.bounce;
        assign state_a[g]  = bus.state;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: pull source (x-cx, y-cy); x wraps unless mode 2, y wraps
    // only in mode 0; an outside source points back at the cell itself.
    function automatic logic [W-1:0] model(input int mode, input int x, input int y);
        logic [9*AW-1:0] src;
        logic [8:0]      bnc;
        int              c;
        int              sx;
        int              sy;
        bit              b;
        c   = y * NXT + x;
        src = '0;
        bnc = '0;
        for (int k = 0; k < 9; k++) begin
            sx = x - DX[k];
            sy = y - DY[k];
            b  = 1'b0;
            if (sx < 0 || sx >= NXT) begin
                if (mode == 2) b = 1'b1;
                else sx = (sx + NXT) % NXT;
            end
            if (sy < 0 || sy >= NYT) begin
                if (mode >= 1) b = 1'b1;
                else sy = (sy + NYT) % NYT;
            end
            src[k*AW +: AW] = AW'(b ? c : sy * NXT + sx);
            bnc[k] = b;
        end
        return {AW'(c), src, bnc, (c == NC - 1)};
    endfunction

    // Transfer monitor and stall-stability checker for the selected DUT.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [50:0]  bundle;
        if (rst_n) begin
            bundle = {vld_a[sel], cell_a[sel], src_a[sel], bounce_a[sel], last_a[sel]};
            if (vld_a[sel]) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_cell observed=cell %0d expected=no valid", cell_a[sel]);
                end
            end
            if (vld_a[sel] && ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                hs_count++;
                chk("cell_addr", 64'(cell_a[sel]), 64'(e[49:46]));
                chk("src_addr",  64'(src_a[sel]),  64'(e[45:10]));
                chk("bounce",    64'(bounce_a[sel]), 64'(e[9:1]));
                chk("step_last", 64'(last_a[sel]), 64'(e[0]));
            end
            if (prev_v && !prev_r) begin
                chk("stall_hold", 64'(bundle), 64'(prev_bundle));
            end
            if (done_a[sel]) begin
                chk("valid_in_done", 64'(vld_a[sel]), 64'(0));
            end
            prev_v      = vld_a[sel];
            prev_r      = ready;
            prev_bundle = bundle;
        end else begin
            prev_v = 1'b0;
        end
    end

    function automatic logic next_ready(input bit rnd);
        return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic push_run(input int s, input int eff);
        for (int t = 0; t < eff; t++)
            for (int yy = 0; yy < NYT; yy++)
                for (int xx = 0; xx < NXT; xx++)
                    exp_q.push_back(model(s, xx, yy));
    endtask

    // One run on DUT s: nst requested, eff expected steps. rnd toggles
    // ready; poke >= 0 pulses start (with a different n_steps) mid-run.
    task automatic run(input int s, input int nst, input int eff, input bit rnd, input int poke);
        int cyc;
        bit seen;
        sel      = s;
        hs_count = 0;
        push_run(s, eff);
        nsteps     = TW'(nst);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        ready      = next_ready(rnd);
        @(negedge clk);
        if (eff > 0) begin
            chk("busy_after_start", 64'(busy_a[s]), 64'(1));
            chk("valid_after_start", 64'(vld_a[s]), 64'(1));
            chk("first_step_count", 64'(step_a[s]), 64'(0));
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20000) begin
            if (done_a[s]) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (cyc == poke) begin
                    start_v[s] = 1'b1;
                    nsteps     = TW'(3);
                end else begin
                    start_v[s] = 1'b0;
                end
                ready = next_ready(rnd);
                cyc++;
                @(negedge clk);
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        if (!rnd) chk("run_cycles", 64'(cyc), 64'(NC * eff));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("handshakes", 64'(hs_count), 64'(NC * eff));
        chk("final_step_count", 64'(step_a[s]), 64'(eff));
        exp_q.delete();
        @(posedge clk);
        #1;
        ready      = 1'b0;
        start_v[s] = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 64'(done_a[s]), 64'(0));
        chk("idle_after_done", 64'(busy_a[s]), 64'(0));
        chk("idle_state", 64'(state_a[s]), 64'(SWEEP_IDLE));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        sel      = 0;
        hs_count = 0;
        prev_v   = 1'b0;
        prev_r   = 1'b0;
        prev_bundle = '0;
        rst_n    = 1'b0;
        start_v  = '0;
        nsteps   = '0;
        ready    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_valid", 64'(vld_a[g]), 64'(0));
            chk("reset_busy", 64'(busy_a[g]), 64'(0));
            chk("reset_done", 64'(done_a[g]), 64'(0));
            chk("reset_step_count", 64'(step_a[g]), 64'(0));
            chk("reset_state", 64'(state_a[g]), 64'(SWEEP_IDLE));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(0, 2, 2, 1'b0, -1);      // periodic, two steps, ready high
        run(1, 1, 1, 1'b0, -1);      // channel walls
        run(2, 1, 1, 1'b1, -1);      // closed box with backpressure
        run(0, 2, 2, 1'b1, -1);      // periodic with backpressure
        run(0, 0, 0, 1'b0, -1);      // zero steps: immediate done
        run(0, 127, 100, 1'b0, -1);  // request above MAX_TIME clamps

        // Reset in the middle of a step.
        sel      = 0;
        hs_count = 0;
        push_run(0, 2);
        nsteps     = TW'(2);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        ready      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_valid", 64'(vld_a[0]), 64'(0));
        chk("midreset_busy", 64'(busy_a[0]), 64'(0));
        chk("midreset_done", 64'(done_a[0]), 64'(0));
        chk("midreset_cell", 64'(cell_a[0]), 64'(0));
        chk("midreset_src", 64'(src_a[0]), 64'(0));
        chk("midreset_bounce", 64'(bounce_a[0]), 64'(0));
        chk("midreset_step_last", 64'(last_a[0]), 64'(0));
        chk("midreset_step_count", 64'(step_a[0]), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        chk("no_done_after_reset", 64'(done_a[0]), 64'(0));
        @(posedge clk);
        #1;

        // Restart after reset, with a start pulse during the sweep that
        // must neither restart nor change the step target.
        run(0, 1, 1, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
